// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the load/store unit: access-size encodings
// and the MEM-stage read-modify-write state type.
package cpu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering: merges sub-word store data into a memory word and
// extracts/extends sub-word load data. Byte lane 0 is bits [31:24].
module lsu_lane_align
  import cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  function automatic logic [31:0] merge_store(input logic [1:0]  sz,
                                              input logic [1:0]  a,
                                              input logic [31:0] wd,
                                              input logic [31:0] word);
    logic [31:0] m;
    m = word;
    if (sz == SIZE_BYTE) begin
      case (a)
        2'd0:    m[31:24] = wd[7:0];
        2'd1:    m[23:16] = wd[7:0];
        2'd2:    m[15:8]  = wd[7:0];
        default: m[7:0]   = wd[7:0];
      endcase
    end else if (sz == SIZE_HALF) begin
      if (a[1]) m[15:0]  = wd[15:0];
      else      m[31:16] = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  function automatic logic [31:0] extract_load(input logic [1:0]  sz,
                                               input logic        uns,
                                               input logic [1:0]  a,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = a[1] ? word[15:0] : word[31:16];
    if (sz == SIZE_BYTE)
      r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
    else if (sz == SIZE_HALF)
      r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
    else
      r = word;
    return r;
  endfunction

  always_comb begin
    merged    = merge_store(size, addr_lo, wdata, rdata);
    load_data = extract_load(size, ld_unsigned, addr_lo, rdata);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, data-memory port driving,
// sub-word stores as a two-cycle read-modify-write that stalls upstream.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_fault
);

  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_BYTES);

  lsu_state_t  state;
  logic        m_read;
  logic        m_write;
  logic [1:0]  m_size;
  logic        m_unsigned;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [4:0]  m_rd;
  logic        m_reg_write;
  logic [31:0] merged_q;

  logic [31:0] merged;
  logic [31:0] load_data;
  logic        is_mem;
  logic        is_load;
  logic        is_sub;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic        rmw_start;

  lsu_lane_align u_align (
    .size        (m_size),
    .ld_unsigned (m_unsigned),
    .addr_lo     (m_addr[1:0]),
    .wdata       (m_wdata),
    .rdata       (dmem_rdata),
    .merged      (merged),
    .load_data   (load_data)
  );

  // A store wins when both read and write are set, so loads need !m_write.
  always_comb begin
    is_mem       = m_read | m_write;
    is_load      = m_read & ~m_write;
    is_sub       = (m_size == SIZE_BYTE) || (m_size == SIZE_HALF);
    misaligned   = ((m_size == SIZE_HALF) && m_addr[0]) ||
                   (m_size[1] && (m_addr[1:0] != 2'b00));
    out_of_range = (m_addr >= DMEM_LIMIT);
    fault        = is_mem & (misaligned | out_of_range);
    rmw_start    = (state == IDLE) & m_write & is_sub & ~fault;
  end

  always_comb begin
    stall      = rmw_start;
    dmem_addr  = {m_addr[31:2], 2'b00};
    dmem_wdata = (state == RMW_WR) ? merged_q : m_wdata;
    // Gated by rst_n so a reset landing on the RMW write cycle cannot corrupt memory.
    dmem_we    = rst_n & ((state == RMW_WR) |
                          ((state == IDLE) & m_write & ~is_sub & ~fault));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_size       <= '0;
      m_unsigned   <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_rd         <= '0;
      m_reg_write  <= 1'b0;
      merged_q     <= '0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      mem_fault    <= 1'b0;
    end else begin
      if (!stall) begin
        m_read      <= ex_mem_read;
        m_write     <= ex_mem_write;
        m_size      <= ex_size;
        m_unsigned  <= ex_unsigned;
        m_addr      <= ex_addr;
        m_wdata     <= ex_wdata;
        m_rd        <= ex_rd;
        m_reg_write <= ex_reg_write;
      end

      case (state)
        IDLE: begin
          if (rmw_start) begin
            state    <= RMW_WR;
            merged_q <= merged;
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase

      // The read half of an RMW retires nothing; the store retires from RMW_WR.
      if (stall) begin
        wb_reg_write <= 1'b0;
        mem_fault    <= 1'b0;
      end else begin
        wb_reg_write <= m_reg_write & ~fault;
        wb_rd        <= m_rd;
        wb_data      <= is_load ? load_data : m_addr;
        mem_fault    <= fault;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single-cycle accesses plus
// hand-written RMW, back-to-back and reset-during-write sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_fault;

  logic [31:0] mem [0:63];
  int nvec;
  int nfail;

  load_store_unit #(.DMEM_BYTES(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_size      (ex_size),
    .ex_unsigned  (ex_unsigned),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .dmem_addr    (dmem_addr),
    .dmem_we      (dmem_we),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mem_fault    (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, word write on rising edge.
  assign dmem_rdata = (dmem_addr < 32'd256) ? mem[dmem_addr[7:2]] : 32'hBAD0BAD0;
  always @(posedge clk) if (dmem_we) mem[dmem_addr[7:2]] <= dmem_wdata;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rdst;
    logic        rw;
    logic        exp_we;
    logic        exp_fault;
    logic        exp_wbrw;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t va [8];
  vec_t vb [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic r, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rdst, input logic rw);
    ex_mem_read  = r;
    ex_mem_write = w;
    ex_size      = sz;
    ex_unsigned  = u;
    ex_addr      = a;
    ex_wdata     = wd;
    ex_rd        = rdst;
    ex_reg_write = rw;
  endtask

  task automatic nop();
    present(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic apply_vec(input vec_t v);
    present(v.rd, v.wr, v.size, v.uns, v.addr, v.wdata, v.rdst, v.rw);
    step();
    chk({v.name, ".we"},    {31'b0, dmem_we}, {31'b0, v.exp_we});
    chk({v.name, ".stall"}, {31'b0, stall},   32'h0);
    nop();
    step();
    chk({v.name, ".wb_rw"}, {31'b0, wb_reg_write}, {31'b0, v.exp_wbrw});
    chk({v.name, ".fault"}, {31'b0, mem_fault},    {31'b0, v.exp_fault});
    if (v.chk_data) chk({v.name, ".data"}, wb_data, v.exp_data);
    if (v.exp_wbrw) chk({v.name, ".rd"}, {27'b0, wb_rd}, {27'b0, v.rdst});
  endtask

  // Byte/half store: stall cycle, then one write cycle carrying the merged word.
  task automatic sub_store(input string nm, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_word);
    present(1'b0, 1'b1, sz, 1'b0, a, wd, 5'd0, 1'b0);
    step();
    chk({nm, ".stall1"}, {31'b0, stall},   32'h1);
    chk({nm, ".we1"},    {31'b0, dmem_we}, 32'h0);
    step();
    chk({nm, ".stall2"}, {31'b0, stall},   32'h0);
    chk({nm, ".we2"},    {31'b0, dmem_we}, 32'h1);
    chk({nm, ".wdata"},  dmem_wdata, exp_word);
    chk({nm, ".addr"},   dmem_addr, {a[31:2], 2'b00});
    nop();
    step();
    chk({nm, ".we3"},    {31'b0, dmem_we}, 32'h0);
    chk({nm, ".wbdata"}, wb_data, a);
    chk({nm, ".mem"},    mem[a[7:2]], exp_word);
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    //              name     rd   wr   sz     u    addr          wdata         rd    rw   we   flt  wbrw chk  data
    va[0] = '{"sw10",     0, 1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 1, 32'h10};
    va[1] = '{"lw10",     1, 0, 2'b10, 0, 32'h10,       32'h0,        5'd5, 1, 0, 0, 1, 1, 32'hDEADBEEF};
    va[2] = '{"alu",      0, 0, 2'b00, 0, 32'h12345678, 32'h0,        5'd3, 1, 0, 0, 1, 1, 32'h12345678};
    va[3] = '{"lw12",     1, 0, 2'b10, 0, 32'h12,       32'h0,        5'd4, 1, 0, 1, 0, 0, 32'h0};
    va[4] = '{"sh13",     0, 1, 2'b01, 0, 32'h13,       32'h1234,     5'd0, 0, 0, 1, 0, 0, 32'h0};
    va[5] = '{"lw100",    1, 0, 2'b10, 0, 32'h100,      32'h0,        5'd6, 1, 0, 1, 0, 0, 32'h0};
    va[6] = '{"sw100",    0, 1, 2'b10, 0, 32'h100,      32'h11111111, 5'd0, 0, 0, 1, 0, 0, 32'h0};
    va[7] = '{"lw11sz",   1, 0, 2'b11, 0, 32'h10,       32'h0,        5'd8, 1, 0, 0, 1, 1, 32'hDEADBEEF};

    vb[0] = '{"lb11",     1, 0, 2'b00, 0, 32'h11, 32'h0, 5'd1,  1, 0, 0, 1, 1, 32'hFFFFFFAD};
    vb[1] = '{"lbu11",    1, 0, 2'b00, 1, 32'h11, 32'h0, 5'd2,  1, 0, 0, 1, 1, 32'h000000AD};
    vb[2] = '{"lh12",     1, 0, 2'b01, 0, 32'h12, 32'h0, 5'd3,  1, 0, 0, 1, 1, 32'h000055EF};
    vb[3] = '{"lhu10",    1, 0, 2'b01, 1, 32'h10, 32'h0, 5'd4,  1, 0, 0, 1, 1, 32'h0000DEAD};
    vb[4] = '{"lh10",     1, 0, 2'b01, 0, 32'h10, 32'h0, 5'd9,  1, 0, 0, 1, 1, 32'hFFFFDEAD};
    vb[5] = '{"lb13",     1, 0, 2'b00, 0, 32'h13, 32'h0, 5'd10, 1, 0, 0, 1, 1, 32'hFFFFFFEF};
    vb[6] = '{"lbu10",    1, 0, 2'b00, 1, 32'h10, 32'h0, 5'd11, 1, 0, 0, 1, 1, 32'h000000DE};
    vb[7] = '{"lb12",     1, 0, 2'b00, 0, 32'h12, 32'h0, 5'd12, 1, 0, 0, 1, 1, 32'h00000055};
    vb[8] = '{"lw10b",    1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd13, 1, 0, 0, 1, 1, 32'hDEAD55EF};

    rst_n = 1'b0;
    nop();
    step();
    step();
    chk("rst.we",    {31'b0, dmem_we},      32'h0);
    chk("rst.stall", {31'b0, stall},        32'h0);
    chk("rst.wbrw",  {31'b0, wb_reg_write}, 32'h0);
    chk("rst.wbrd",  {27'b0, wb_rd},        32'h0);
    chk("rst.wbdat", wb_data,               32'h0);
    chk("rst.fault", {31'b0, mem_fault},    32'h0);
    chk("rst.addr",  dmem_addr,             32'h0);
    chk("rst.wdata", dmem_wdata,            32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) apply_vec(va[i]);

    sub_store("sb12", 2'b00, 32'h12, 32'h00000055, 32'hDEAD55EF);

    for (int i = 0; i < 9; i++) apply_vec(vb[i]);

    sub_store("sh10", 2'b01, 32'h10, 32'h0000ABCD, 32'hABCD55EF);

    // ALU op, sb, lw back to back with upstream honouring stall.
    present(1'b0, 1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 5'd2, 1'b1);
    step();
    present(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h77, 5'd0, 1'b0);
    step();
    chk("b2b.stall", {31'b0, stall},        32'h1);
    chk("b2b.aluwb", {31'b0, wb_reg_write}, 32'h1);
    chk("b2b.aludt", wb_data,               32'h55);
    step();
    chk("b2b.bubble", {31'b0, wb_reg_write}, 32'h0);
    chk("b2b.we",     {31'b0, dmem_we},      32'h1);
    chk("b2b.wdata",  dmem_wdata,            32'hABCD5577);
    present(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7, 1'b1);
    step();
    chk("b2b.lwwe",  {31'b0, dmem_we}, 32'h0);
    chk("b2b.lwst",  {31'b0, stall},   32'h0);
    chk("b2b.sbwb",  wb_data,          32'h13);
    nop();
    step();
    chk("b2b.lwrw",  {31'b0, wb_reg_write}, 32'h1);
    chk("b2b.lwrd",  {27'b0, wb_rd},        32'h7);
    chk("b2b.lwdat", wb_data,               32'hABCD5577);
    step();
    chk("b2b.nodup", {31'b0, wb_reg_write}, 32'h0);

    // Reset landing on the RMW write cycle.
    present(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h99, 5'd0, 1'b0);
    step();
    chk("rrmw.stall", {31'b0, stall}, 32'h1);
    step();
    chk("rrmw.we1", {31'b0, dmem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rrmw.we0", {31'b0, dmem_we}, 32'h0);
    nop();
    step();
    chk("rrmw.we",    {31'b0, dmem_we},      32'h0);
    chk("rrmw.stall2",{31'b0, stall},        32'h0);
    chk("rrmw.wbrw",  {31'b0, wb_reg_write}, 32'h0);
    chk("rrmw.wbrd",  {27'b0, wb_rd},        32'h0);
    chk("rrmw.wbdat", wb_data,               32'h0);
    chk("rrmw.fault", {31'b0, mem_fault},    32'h0);
    chk("rrmw.addr",  dmem_addr,             32'h0);
    chk("rrmw.wdata", dmem_wdata,            32'h0);
    chk("rrmw.mem",   mem[4],                32'hABCD5577);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
